// File: rtl/wb_pkg.sv
// Writeback stage shared definitions.
// Load-size encodings and default widths.
package wb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

endpackage

// File: rtl/writeback_load_align.sv
// Little-endian load lane select and extension.
// Purely combinational; size 11 falls back to word.
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        offset,
    input  logic [1:0]        load_size,
    input  logic              load_signed,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [7:0]        b;
    logic [15:0]       h;

    assign byte_sh = mem_data >> {offset, 3'b000};
    assign half_sh = mem_data >> {offset[1], 4'b0000};
    assign b       = byte_sh[7:0];
    assign h       = half_sh[15:0];

    // Pick lane and extend according to size and signedness
    always_comb begin
        data = mem_data;
        unique case (load_size)
            LS_BYTE: data = {{(DATA_W-8){load_signed & b[7]}}, b};
            LS_HALF: data = {{(DATA_W-16){load_signed & h[15]}}, h};
            default: data = mem_data;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback pipeline stage with retire counter.
// Define WB_FORWARD_EN to add rs/rt forwarding outputs.
module writeback
    import wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic                  in_load_signed,
    input  logic [1:0]            in_load_size,
    input  logic [REG_ADDR_W-1:0] in_write_reg,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_data,
`ifdef WB_FORWARD_EN
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  fwd_a,
    output logic                  fwd_b,
    output logic [DATA_W-1:0]     fwd_data,
`endif
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic                  reg_write,
    output logic [31:0]           retire_count
);

    logic                  valid_q;
    logic                  reg_write_q;
    logic                  mem_to_reg_q;
    logic                  load_signed_q;
    logic [1:0]            load_size_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0]     alu_result_q;
    logic [DATA_W-1:0]     mem_data_q;
    logic [31:0]           retire_q;
    logic [DATA_W-1:0]     load_data;

    // Valid bit: flush kills even while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= 1'b0;
        else if (flush)
            valid_q <= 1'b0;
        else if (!stall)
            valid_q <= in_valid;
    end

    // Payload fields: captured whenever not stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            load_signed_q <= 1'b0;
            load_size_q   <= 2'b00;
            write_reg_q   <= '0;
            alu_result_q  <= '0;
            mem_data_q    <= '0;
        end else if (!stall) begin
            reg_write_q   <= in_reg_write;
            mem_to_reg_q  <= in_mem_to_reg;
            load_signed_q <= in_load_signed;
            load_size_q   <= in_load_size;
            write_reg_q   <= in_write_reg;
            alu_result_q  <= in_alu_result;
            mem_data_q    <= in_mem_data;
        end
    end

    // Count accepted, unflushed valid instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_q <= '0;
        else if (!stall && !flush && in_valid)
            retire_q <= retire_q + 32'd1;
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .mem_data    (mem_data_q),
        .offset      (alu_result_q[1:0]),
        .load_size   (load_size_q),
        .load_signed (load_signed_q),
        .data        (load_data)
    );

    assign write_reg    = write_reg_q;
    assign write_data   = mem_to_reg_q ? load_data : alu_result_q;
    assign reg_write    = valid_q & reg_write_q & (write_reg_q != '0);
    assign retire_count = retire_q;

`ifdef WB_FORWARD_EN
    assign fwd_a    = reg_write & (rs == write_reg);
    assign fwd_b    = reg_write & (rt == write_reg);
    assign fwd_data = write_data;
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for the writeback stage.
// Table vectors via scoreboard queue plus stall/flush/reset/wrap sequences.
module tb_writeback;

    typedef struct {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        sgn;
        logic [1:0]  size;
        logic [4:0]  wreg;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        exp_rw;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  wreg;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, in_valid;
    logic        in_reg_write, in_mem_to_reg, in_load_signed;
    logic [1:0]  in_load_size;
    logic [4:0]  in_write_reg;
    logic [31:0] in_alu_result, in_mem_data;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] retire_count;
`ifdef WB_FORWARD_EN
    logic [4:0]  rs, rt;
    logic        fwd_a, fwd_b;
    logic [31:0] fwd_data;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_cnt;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    writeback dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_reg_write   (in_reg_write),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_load_signed (in_load_signed),
        .in_load_size   (in_load_size),
        .in_write_reg   (in_write_reg),
        .in_alu_result  (in_alu_result),
        .in_mem_data    (in_mem_data),
`ifdef WB_FORWARD_EN
        .rs             (rs),
        .rt             (rt),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .fwd_data       (fwd_data),
`endif
        .write_reg      (write_reg),
        .write_data     (write_data),
        .reg_write      (reg_write),
        .retire_count   (retire_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic rw, input logic m2r,
                       input logic sgn, input logic [1:0] sz,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] mem, input logic erw,
                       input logic [31:0] ed);
        vec_t t;
        t.valid = v; t.rw = rw; t.m2r = m2r; t.sgn = sgn;
        t.size = sz; t.wreg = wr; t.alu = alu; t.mem = mem;
        t.exp_rw = erw; t.exp_data = ed;
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        in_valid       = t.valid;
        in_reg_write   = t.rw;
        in_mem_to_reg  = t.m2r;
        in_load_signed = t.sgn;
        in_load_size   = t.size;
        in_write_reg   = t.wreg;
        in_alu_result  = t.alu;
        in_mem_data    = t.mem;
    endtask

    localparam logic [31:0] MD = 32'h80FF7F01;

    initial begin
        vec_t v;
        exp_t e;
        logic [31:0] held;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0;
        in_load_signed = 0; in_load_size = 0; in_write_reg = 0;
        in_alu_result = 0; in_mem_data = 0;
`ifdef WB_FORWARD_EN
        rs = 0; rt = 0;
`endif
        exp_cnt = 0;

        // valid rw m2r sgn size wreg alu mem exp_rw exp_data
        add(1, 1, 0, 0, 2'b00, 5'd7, 32'h12345678, 0, 1, 32'h12345678);
        add(1, 1, 1, 1, 2'b10, 5'd5, 32'h3, MD, 1, 32'hFFFFFF80);
        add(1, 1, 1, 0, 2'b01, 5'd6, 32'h2, MD, 1, 32'h000080FF);
        add(1, 1, 1, 0, 2'b00, 5'd8, 32'h0, MD, 1, 32'h80FF7F01);
        add(1, 1, 1, 1, 2'b01, 5'd9, 32'h1, MD, 1, 32'h00007F01);
        add(1, 1, 1, 1, 2'b01, 5'd9, 32'h3, MD, 1, 32'hFFFF80FF);
        add(1, 1, 1, 0, 2'b10, 5'd10, 32'h2, MD, 1, 32'h000000FF);
        add(1, 1, 1, 1, 2'b10, 5'd10, 32'h2, MD, 1, 32'hFFFFFFFF);
        add(1, 1, 1, 1, 2'b10, 5'd11, 32'h1, MD, 1, 32'h0000007F);
        add(1, 1, 1, 0, 2'b10, 5'd11, 32'h0, MD, 1, 32'h00000001);
        add(1, 1, 1, 1, 2'b11, 5'd12, 32'h3, MD, 1, 32'h80FF7F01);
        add(1, 1, 0, 0, 2'b00, 5'd0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
        add(0, 1, 0, 0, 2'b00, 5'd13, 32'hCAFE0000, 0, 0, 32'hCAFE0000);
        add(1, 0, 0, 0, 2'b00, 5'd14, 32'h0BADF00D, 0, 0, 32'h0BADF00D);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_write", {31'd0, reg_write}, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_count", retire_count, 0);
        @(negedge clk) rst_n = 1'b1;

        // Table vectors through the scoreboard
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            if (vecs[i].valid) exp_cnt = exp_cnt + 1;
            e.rw = vecs[i].exp_rw; e.wreg = vecs[i].wreg;
            e.data = vecs[i].exp_data; e.cnt = exp_cnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_rw", i), {31'd0, reg_write}, {31'd0, e.rw});
                chk($sformatf("v%0d_wreg", i), {27'd0, write_reg}, {27'd0, e.wreg});
                chk($sformatf("v%0d_data", i), write_data, e.data);
                chk($sformatf("v%0d_cnt", i), retire_count, e.cnt);
            end
        end

        // Stall holds outputs for 3 cycles
        @(negedge clk);
        v = vecs[0]; v.wreg = 5'd7; v.alu = 32'hAAAA5555;
        drive(v);
        exp_cnt = exp_cnt + 1;
        @(posedge clk); #1;
        chk("pre_stall_data", write_data, 32'hAAAA5555);
        @(negedge clk);
        stall = 1'b1;
        in_write_reg = 5'd3; in_alu_result = 32'h0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_rw", {31'd0, reg_write}, 1);
            chk("stall_wreg", {27'd0, write_reg}, 7);
            chk("stall_data", write_data, 32'hAAAA5555);
            chk("stall_cnt", retire_count, exp_cnt);
        end

        // Flush overrides stall
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        chk("sflush_rw", {31'd0, reg_write}, 0);
        chk("sflush_wreg", {27'd0, write_reg}, 7);
        chk("sflush_cnt", retire_count, exp_cnt);

        // Flush without stall: valid input not retired
        @(negedge clk) stall = 1'b0;
        @(posedge clk); #1;
        chk("flush_rw", {31'd0, reg_write}, 0);
        chk("flush_cnt", retire_count, exp_cnt);
        @(negedge clk) flush = 1'b0;

        // Counter wrap
        force dut.retire_q = 32'hFFFFFFFF;
        #1 release dut.retire_q;
        v = vecs[0];
        drive(v);
        @(posedge clk); #1;
        chk("wrap_cnt", retire_count, 32'h0);
        exp_cnt = 0;

`ifdef WB_FORWARD_EN
        // Forwarding match on rs only
        @(negedge clk);
        v = vecs[0]; v.wreg = 5'd9; v.alu = 32'h00C0FFEE;
        drive(v);
        rs = 5'd9; rt = 5'd4;
        @(posedge clk); #1;
        chk("fwd_a", {31'd0, fwd_a}, 1);
        chk("fwd_b", {31'd0, fwd_b}, 0);
        chk("fwd_data", fwd_data, 32'h00C0FFEE);
`endif

        // Asynchronous reset mid-run
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rw", {31'd0, reg_write}, 0);
        chk("arst_wreg", {27'd0, write_reg}, 0);
        chk("arst_data", write_data, 0);
        chk("arst_cnt", retire_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_rst_rw", {31'd0, reg_write}, 0);
            chk("post_rst_cnt", retire_count, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
